// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- register file with a per-register pending (scoreboard) bit.
//
// Two combinational read ports return register data and its pending flag.
// An issue request marks its destination pending, and a later writeback
// clears it. pend_cnt tracks how many registers are pending.
//
// Ports:
//   clk                  sole clock, rising edge
//   reset                synchronous, active-low reset
//   rd_addr_1/2          read addresses
//   rd_data_1/2          read data (combinational)
//   rd_pend_1/2          addressed register has an outstanding write
//   wr_en/addr/data      writeback strobe, address, data
//   iss_en/iss_addr      issue request and its destination
//   iss_stall            issue refused because the destination is pending
//   pend_cnt             registered number of pending registers
//
// Optional feature macro: REGFILE_SB_BYPASS_EN
//   Defined   : a writeback is forwarded to matching read ports in the same cycle.
//   Undefined : reads return stored values only.
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_pend_1,
  output logic              rd_pend_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_stall,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_d;

  logic wr_ok_s;
  logic same_s;
  logic iss_set_s;
  logic set_new_s;
  logic clr_s;

  // True when the address is the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_ZERO);
  endfunction

  // Decode of writeback / issue qualifiers; all gated off while in reset.
  always_comb begin
    wr_ok_s   = reset & wr_en & ~is_zero(wr_addr);
    same_s    = iss_en & wr_en & (iss_addr == wr_addr);
    // A same-address writeback hands the register straight to the new issue,
    // so the issue is accepted even when the register is currently pending.
    iss_set_s = reset & iss_en & ~is_zero(iss_addr) & (same_s | ~pend_q[iss_addr]);
    iss_stall = reset & iss_en & pend_q[iss_addr] & ~same_s;
    set_new_s = iss_set_s & ~pend_q[iss_addr];
    clr_s     = wr_ok_s & pend_q[wr_addr] & ~(iss_set_s & same_s);
  end

  // Next pending vector and count: clear on writeback, then set on issue.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok_s) begin
      pend_d[wr_addr] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (iss_set_s) begin
      pend_d[iss_addr] = 1'b1;
    end else begin
      pend_d[iss_addr] = pend_d[iss_addr];
    end
    pend_cnt_d = pend_cnt_q + {{ADDR_W{1'b0}}, set_new_s} - {{ADDR_W{1'b0}}, clr_s};
  end

  // Register array, pending vector and count with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_ZERO;
      end
      pend_q     <= {DEPTH{1'b0}};
      pend_cnt_q <= CNT_ZERO;
    end else begin
      if (wr_ok_s) begin
        mem_q[wr_addr] <= wr_data;
      end
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  // Read port 1: zero register, optional same-cycle forwarding, stored state.
  always_comb begin
    rd_data_1 = mem_q[rd_addr_1];
    rd_pend_1 = pend_q[rd_addr_1];
    if (is_zero(rd_addr_1)) begin
      rd_data_1 = DATA_ZERO;
      rd_pend_1 = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    end else if (wr_ok_s && (rd_addr_1 == wr_addr)) begin
      rd_data_1 = wr_data;
      rd_pend_1 = 1'b0;
`endif
    end else begin
      rd_data_1 = mem_q[rd_addr_1];
      rd_pend_1 = pend_q[rd_addr_1];
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    rd_data_2 = mem_q[rd_addr_2];
    rd_pend_2 = pend_q[rd_addr_2];
    if (is_zero(rd_addr_2)) begin
      rd_data_2 = DATA_ZERO;
      rd_pend_2 = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    end else if (wr_ok_s && (rd_addr_2 == wr_addr)) begin
      rd_data_2 = wr_data;
      rd_pend_2 = 1'b0;
`endif
    end else begin
      rd_data_2 = mem_q[rd_addr_2];
      rd_pend_2 = pend_q[rd_addr_2];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- self-checking bench for regfile_sb (default parameters).
// A behavioural model (data array plus pending bit-vector, count taken as its
// population) is updated once per rising edge. All outputs are compared on
// the falling edge, and directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_1, rd_addr_2;
  logic [31:0] rd_data_1, rd_data_2;
  logic        rd_pend_1, rd_pend_2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_stall;
  logic [5:0]  pend_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m [32];
  logic [31:0] pend_m;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_pend_1(rd_pend_1), .rd_pend_2(rd_pend_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    rd_addr_1 = ra1; rd_addr_2 = ra2;
  endtask

  // Expected read result from the model for the current inputs.
  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic p);
    if (a == 5'd0) begin
      d = 32'd0; p = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    end else if (reset && wr_en && a == wr_addr) begin
      d = wr_data; p = 1'b0;
`endif
    end else begin
      d = mem_m[a]; p = pend_m[a];
    end
  endtask

  // Compare every output against the model, then advance both by one edge.
  task automatic cycle();
    logic [31:0] ed;
    logic        ep;
    logic        estall;
    @(negedge clk);
    model_read(rd_addr_1, ed, ep);
    check_eq("rd_data_1", {32'd0, rd_data_1}, {32'd0, ed});
    check_eq("rd_pend_1", {63'd0, rd_pend_1}, {63'd0, ep});
    model_read(rd_addr_2, ed, ep);
    check_eq("rd_data_2", {32'd0, rd_data_2}, {32'd0, ed});
    check_eq("rd_pend_2", {63'd0, rd_pend_2}, {63'd0, ep});
    estall = reset && iss_en && pend_m[iss_addr] && !(wr_en && wr_addr == iss_addr);
    check_eq("iss_stall", {63'd0, iss_stall}, {63'd0, estall});
    check_eq("pend_cnt", {58'd0, pend_cnt}, 64'($countones(pend_m)));
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
      pend_m = 32'd0;
    end else begin
      logic was_pend;
      was_pend = pend_m[iss_addr];
      if (wr_en && wr_addr != 5'd0) begin
        mem_m[wr_addr] = wr_data;
        pend_m[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 5'd0) begin
        if ((wr_en && wr_addr == iss_addr) || !was_pend) pend_m[iss_addr] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
    pend_m = 32'd0;

    // Reset held two cycles while a write is attempted to r3.
    reset = 1'b0;
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 5'd3, 5'd3);
    @(posedge clk); #1;
    cycle();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    #1;
    check_eq("rst_data", {32'd0, rd_data_1}, 64'd0);
    check_eq("rst_cnt", {58'd0, pend_cnt}, 64'd0);

    // Write then read r3 on both ports.
    drive(1'b1, 5'd3, 32'h1234AAAA, 1'b0, 5'd0, 5'd3, 5'd3);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    #1;
    check_eq("wr_rd_1", {32'd0, rd_data_1}, {32'd0, 32'h1234AAAA});
    check_eq("wr_rd_2", {32'd0, rd_data_2}, {32'd0, 32'h1234AAAA});

    // Scoreboard on r5: issue, repeated issue stalls, writeback clears.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd3);
    cycle();
    #1;
    check_eq("sb_pend", {63'd0, rd_pend_1}, 64'd1);
    check_eq("sb_cnt1", {58'd0, pend_cnt}, 64'd1);
    check_eq("sb_stall", {63'd0, iss_stall}, 64'd1);
    cycle();
    check_eq("sb_cnt2", {58'd0, pend_cnt}, 64'd1);
    drive(1'b1, 5'd5, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd5, 5'd5);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    #1;
    check_eq("sb_clr", {63'd0, rd_pend_1}, 64'd0);
    check_eq("sb_cnt0", {58'd0, pend_cnt}, 64'd0);
    check_eq("sb_data", {32'd0, rd_data_1}, {32'd0, 32'hFFFFFFFF});

    // Simultaneous issue + writeback to pending r7.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);
    cycle();
    drive(1'b1, 5'd7, 32'hEEEEAAAA, 1'b1, 5'd7, 5'd7, 5'd7);
    #1;
    check_eq("sim_stall", {63'd0, iss_stall}, 64'd0);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    check_eq("sim_data", {32'd0, rd_data_1}, {32'd0, 32'hEEEEAAAA});
    check_eq("sim_pend", {63'd0, rd_pend_1}, 64'd1);
    check_eq("sim_cnt", {58'd0, pend_cnt}, 64'd1);
    drive(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 5'd7, 5'd7);
    cycle();

    // Zero register: write and issue together are both dropped.
    drive(1'b1, 5'd0, 32'hEEEEAAA0, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    check_eq("z_stall", {63'd0, iss_stall}, 64'd0);
    cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check_eq("z_data", {32'd0, rd_data_1}, 64'd0);
    check_eq("z_pend", {63'd0, rd_pend_1}, 64'd0);
    check_eq("z_cnt", {58'd0, pend_cnt}, 64'd0);

    // Fill r1..r31, then a one-cycle reset discards everything.
    for (int a = 1; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(a), 5'(a - 1));
      cycle();
    end
    check_eq("fill_cnt", {58'd0, pend_cnt}, 64'd31);
    reset = 1'b0;
    drive(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 5'd9, 5'd1);
    cycle();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check_eq("mid_cnt", {58'd0, pend_cnt}, 64'd0);
    for (int a = 0; a < 32; a++) begin
      rd_addr_1 = 5'(a);
      #1;
      check_eq("mid_pend", {63'd0, rd_pend_1}, 64'd0);
    end

    // Random traffic; addresses are often drawn from a small range to provoke
    // same-address collisions and stalls.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] wa, ia;
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ia = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      drive(1'($urandom_range(0, 1)), wa, $urandom(), 1'($urandom_range(0, 1)), ia,
            ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 1) == 0) ? ia : 5'($urandom_range(0, 31)));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and is never written or marked pending.
REQ-004 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock; rising edge.
- reset  in  1  synchronous, active-low reset.
- rd_addr_1, rd_addr_2  in  ADDR_W  read port addresses.
- rd_data_1, rd_data_2  out  DATA_W  read data.
- rd_pend_1, rd_pend_2  out  1  addressed register has an outstanding write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue request: mark iss_addr pending.
- iss_addr  in  ADDR_W  issue destination.
- iss_stall  out  1  issue refused because iss_addr is already pending.
- pend_cnt  out  ADDR_W+1  number of registers currently pending.
REQ-005 Reset SHALL be synchronous and active-low, and clk SHALL be the only clock.

Function
REQ-006 Read ports SHALL be combinational (zero latency) from the stored register array and the pending vector.
REQ-007 On a rising clk with reset high and wr_en=1, mem[wr_addr] SHALL take wr_data and pend[wr_addr] SHALL clear; the write SHALL be visible on reads the next cycle.
REQ-008 A write to a non-pending register SHALL update the data and leave pend at 0.
REQ-009 With iss_en=1 and pend[iss_addr]=0, pend[iss_addr] SHALL set on the next rising edge.
REQ-010 iss_stall SHALL equal iss_en & pend[iss_addr]; a stalled issue SHALL change no state.
REQ-011 If iss_en and wr_en target the same address in the same cycle:
- If that register is pending, the write SHALL complete and pend SHALL remain 1, because the new issue owns the register.
- If that register is not pending, data SHALL be written and pend SHALL be set.
- iss_stall SHALL be 0 in this case.
REQ-012 With ZERO_REG=1, the following SHALL hold:
- Address 0 SHALL read 0 with rd_pend=0.
- Writes to address 0 SHALL be dropped.
- An issue to address 0 SHALL be accepted with iss_stall=0 and SHALL set no pend bit.
REQ-013 pend_cnt SHALL be a registered count equal to the population of pend after each edge.
- +1 on an accepted set.
- -1 on a clear.
- Unchanged when a set and a clear occur together.
- The count SHALL never exceed DEPTH and SHALL never wrap below 0.
REQ-014 All arithmetic SHALL be unsigned, and address comparisons SHALL use full ADDR_W bits.

Reset
REQ-015 While reset=0 at a rising edge, all registers SHALL be set to 0, pend to all-0 and pend_cnt to 0, and wr_en/iss_en SHALL be ignored.
REQ-016 During reset, iss_stall SHALL be 0, and rd_data/rd_pend SHALL reflect the cleared state from the cycle after the first reset edge.
REQ-017 A reset asserted mid-operation SHALL discard all pending state; writebacks arriving after reset release SHALL be treated as writes to non-pending registers.

Configuration
REQ-018 The macro REGFILE_SB_BYPASS_EN SHALL control write-to-read forwarding.
- Defined: when wr_en=1, reset=1 and rd_addr_n==wr_addr (nonzero if ZERO_REG=1), rd_data_n SHALL equal wr_data and rd_pend_n SHALL be 0 in the same cycle.
- Defined: if iss_en targets the same address in that cycle, rd_pend_n SHALL still be 0 for that cycle.
- Undefined: reads SHALL return stored values only, with the write visible one cycle later.

Verification
REQ-019 Reset: hold reset=0 for 2 cycles with wr_en=1, wr_addr=3, wr_data=32'hDEADBEEF -> rd_data_1 at addr 3 = 0 and pend_cnt=0 after release.
REQ-020 Write/read: wr 32'h1234AAAA to r3, then read r3 on both ports -> 32'h1234AAAA the next cycle; with BYPASS_EN, the value appears in the same cycle.
REQ-021 Scoreboard: issue r5 -> rd_pend=1 and pend_cnt=1; issue r5 again -> iss_stall=1 and pend_cnt=1; wr r5 = 32'hFFFFFFFF -> pend=0, pend_cnt=0, data FFFFFFFF.
REQ-022 Simultaneous: with r7 pending, iss_en and wr_en to r7 with data 32'hEEEEAAAA -> data EEEEAAAA, rd_pend=1, pend_cnt unchanged, iss_stall=0.
REQ-023 Zero register: wr 32'hEEEEAAA0 to r0 and issue r0 -> rd_data=0, rd_pend=0, pend_cnt=0.
REQ-024 Fill/reset mid-op: issue r1..r31 -> pend_cnt=31; then assert reset for one cycle -> pend_cnt=0 and all rd_pend=0.
